uart_8n1_receiver: RTL and testbench

Receive half of the 8N1 UART pair: deserialises a 1-start, 8-data (LSB first), no-parity, 1-stop frame from the asynchronous `rx` line using a 16× baud clock. It presents each received byte in a holding register with a valid/read handshake, and flags framing errors and overruns. It sits between the board pin and any byte-wide consumer, mirroring `uart_8n1_transmitter` on the same `clk_baud_16x` domain.

---
 rtl/uart_8n1_receiver.sv | 128 ++++++++++++
 tb/tb_uart_8n1_receiver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_8n1_receiver.sv
// 8N1 UART receiver on a 16x baud clock with a valid/read holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling at each bit sample point.
module uart_8n1_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_baud_16x,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] recv_data,
  output logic       recv_valid,
  input  logic       recv_read,
  output logic       recv_frame_error,
  output logic       recv_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic                   sample;
  logic [3:0]             tick;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;

  // Flops preset high so reset never looks like a start edge.
  always_ff @(posedge clk_baud_16x or negedge reset) begin
    if (!reset) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist;

  always_ff @(posedge clk_baud_16x or negedge reset) begin
    if (!reset) hist <= 2'b11;
    else        hist <= {hist[0], rxs};
  end

  // Current value plus the two previous cycles, so the decision edge stays put.
  assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rxs;
`endif

  always_ff @(posedge clk_baud_16x or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      tick             <= 4'd0;
      bit_cnt          <= 3'd0;
      shift            <= 8'h00;
      recv_data        <= 8'h00;
      recv_valid       <= 1'b0;
      recv_frame_error <= 1'b0;
      recv_overrun     <= 1'b0;
    end else begin
      if (recv_read && recv_valid) begin
        recv_valid       <= 1'b0;
        recv_frame_error <= 1'b0;
        recv_overrun     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            tick  <= 4'd0;
          end
        end
        START: begin
          if (tick == 4'd7) begin
            if (!sample) begin
              state   <= DATA;
              tick    <= 4'd0;
              bit_cnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick <= tick + 4'd1;
          end
        end
        DATA: begin
          if (tick == 4'd15) begin
            shift   <= {sample, shift[7:1]};
            tick    <= 4'd0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            tick <= tick + 4'd1;
          end
        end
        STOP: begin
          if (tick == 4'd15) begin
            tick <= 4'd0;
            if (sample) begin
              // A load on the same edge as a read overrides the read's clear of valid.
              if (!recv_valid || recv_read) begin
                recv_data  <= shift;
                recv_valid <= 1'b1;
              end else begin
                recv_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              recv_frame_error <= 1'b1;
              state            <= BREAK;
            end
          end else begin
            tick <= tick + 4'd1;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_8n1_receiver.sv
// Directed bench for uart_8n1_receiver: latency, handshake, overrun, framing, glitch and reset cases.
module tb_uart_8n1_receiver;

  logic       clk_baud_16x = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       recv_read = 1'b0;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       recv_frame_error;
  logic       recv_overrun;

  int total = 0;
  int bad = 0;

  uart_8n1_receiver #(.SYNC_STAGES(2)) dut (
    .clk_baud_16x     (clk_baud_16x),
    .reset            (reset),
    .rx               (rx),
    .recv_data        (recv_data),
    .recv_valid       (recv_valid),
    .recv_read        (recv_read),
    .recv_frame_error (recv_frame_error),
    .recv_overrun     (recv_overrun)
  );

  always #5 clk_baud_16x = ~clk_baud_16x;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                           input logic fe, input logic ov);
    check({tag, "_data"}, recv_data, d);
    check({tag, "_valid"}, {7'd0, recv_valid}, {7'd0, v});
    check({tag, "_ferr"}, {7'd0, recv_frame_error}, {7'd0, fe});
    check({tag, "_ovr"}, {7'd0, recv_overrun}, {7'd0, ov});
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk_baud_16x);
      #1;
    end
  endtask

  task automatic read_pulse();
    recv_read = 1'b1;
    @(posedge clk_baud_16x);
    #1;
    recv_read = 1'b0;
  endtask

  // Edge e of the frame is the (e+1)-th rising edge after the call; rx is set before it.
  task automatic send(input logic [7:0] d, input logic stop_bit, input int glitch,
                      input int abort, input bit lat);
    for (int e = 0; e < 160; e++) begin
      automatic int b = e / 16;
      automatic logic v;
      v = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop_bit;
      if (e == glitch) v = ~v;
      rx = v;
      @(posedge clk_baud_16x);
      #1;
      if (lat && e == 153) check("lat_edge153_valid", {7'd0, recv_valid}, 8'd0);
      if (lat && e == 154) begin
        check("lat_edge154_valid", {7'd0, recv_valid}, 8'd1);
        check("lat_edge154_data", recv_data, d);
      end
      if (e == abort) begin
        reset = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (2) @(posedge clk_baud_16x);
        #1;
        reset = 1'b1;
        return;
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    #3;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk_baud_16x);
    #1;
    reset = 1'b1;
    idle(5);

    send(8'h42, 1'b1, -1, -1, 1'b1);
    idle(4);
    check_all("frame42", 8'h42, 1'b1, 1'b0, 1'b0);

    read_pulse();
    check("read_clears_valid", {7'd0, recv_valid}, 8'd0);
    send(8'hCA, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("frameCA", 8'hCA, 1'b1, 1'b0, 1'b0);

    read_pulse();
    send(8'h42, 1'b1, -1, -1, 1'b0);
    send(8'hCA, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("overrun", 8'h42, 1'b1, 1'b0, 1'b1);
    read_pulse();
    check_all("overrun_cleared", 8'h42, 1'b0, 1'b0, 1'b0);

    send(8'h55, 1'b0, -1, -1, 1'b0);
    rx = 1'b0;
    repeat (24) begin
      @(posedge clk_baud_16x);
      #1;
    end
    idle(30);
    check_all("frame_err", 8'h42, 1'b0, 1'b1, 1'b0);
    send(8'h42, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("after_break", 8'h42, 1'b1, 1'b1, 1'b0);
    read_pulse();
    check_all("ferr_cleared", 8'h42, 1'b0, 1'b0, 1'b0);

    rx = 1'b0;
    repeat (4) begin
      @(posedge clk_baud_16x);
      #1;
    end
    idle(40);
    check_all("glitch_idle", 8'h42, 1'b0, 1'b0, 1'b0);
    send(8'h99, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("post_glitch_frame", 8'h99, 1'b1, 1'b0, 1'b0);
    read_pulse();

`ifdef UART_RX_MAJORITY_VOTE_EN
    send(8'hFF, 1'b1, 72, -1, 1'b0);
    idle(4);
    check_all("vote_glitch", 8'hFF, 1'b1, 1'b0, 1'b0);
    read_pulse();
`endif

    send(8'h3C, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("pre_abort", 8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'h81, 1'b1, -1, 74, 1'b0);
    idle(20);
    check_all("post_abort_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 1'b1, -1, -1, 1'b0);
    idle(4);
    check_all("frameA5", 8'hA5, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
